cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_pkg.sv | 18 +
 rtl/cache_ctrl_if.sv | 32 +++
 rtl/cache.sv | 44 ++++
 rtl/cache_ctrl.sv | 108 ++++++++++
 tb/tb_cache_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM encoding and statistics helpers for cache_ctrl
package cache_pkg;

  localparam int CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_RD,
    MEM_WR,
    RESP
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// rtl/cache_ctrl_if.sv - CPU request/response and backing-memory bus of cache_ctrl
interface cache_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);

  logic                  req_valid;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_ready;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // master is the CPU plus memory side; slave is the controller
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache.sv
// rtl/cache.sv - direct-mapped tag/data store with combinational lookup
module cache
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int CELL_CNT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  hit
);

  // CELL_CNT is a power of two; the low address bits select the entry
  localparam int IDX_W = (CELL_CNT > 1) ? $clog2(CELL_CNT) : 1;

  logic [CELL_CNT-1:0]   valid_q;
  logic [ADDR_WIDTH-1:0] tag_q  [CELL_CNT];
  logic [DATA_WIDTH-1:0] data_q [CELL_CNT];
  logic [IDX_W-1:0]      idx;

  assign idx   = addr[IDX_W-1:0];
  assign hit   = valid_q[idx] && (tag_q[idx] == addr);
  assign rdata = data_q[idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < CELL_CNT; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (we) begin
      valid_q[idx] <= 1'b1;
      tag_q[idx]   <= addr;
      data_q[idx]  <= wdata;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - write-through, write-allocate cache controller with hit/miss statistics
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int CELL_CNT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_ctrl_if.slave          bus,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CNT_WIDTH-1:0]  hit_q, hit_d, miss_q, miss_d;
  logic                  cache_we, cache_hit;
  logic [DATA_WIDTH-1:0] cache_wdata, cache_rdata;

  cache #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .CELL_CNT  (CELL_CNT)
  ) u_cache (
    .clk  (clk),
    .rst  (rst),
    .we   (cache_we),
    .addr (addr_q),
    .wdata(cache_wdata),
    .rdata(cache_rdata),
    .hit  (cache_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      if (state_q == IDLE && bus.req_valid) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        we_q    <= bus.req_we;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cache_we    = 1'b0;
    cache_wdata = wdata_q;
    rdata_d     = rdata_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    case (state_q)
      IDLE:   if (bus.req_valid) state_d = LOOKUP;
      LOOKUP: begin
        if (we_q) begin
          cache_we = 1'b1;
          state_d  = MEM_WR;
        end else if (cache_hit) begin
          rdata_d = cache_rdata;
          hit_d   = sat_inc(hit_q);
          state_d = RESP;
        end else begin
          miss_d  = sat_inc(miss_q);
          state_d = MEM_RD;
        end
      end
      MEM_RD: begin
        if (bus.mem_ack) begin
          cache_we    = 1'b1;
          cache_wdata = bus.mem_rdata;
          rdata_d     = bus.mem_rdata;
          state_d     = RESP;
        end
      end
      MEM_WR: if (bus.mem_ack) state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // memory request is a pure state decode so reset drops it asynchronously
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_req   = (state_q == MEM_RD) || (state_q == MEM_WR);
  assign bus.mem_we    = (state_q == MEM_WR);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign hit_cnt       = hit_q;
  assign miss_cnt      = miss_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - directed self-checking bench for cache_ctrl
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] hit_cnt, miss_cnt;
  int          compared = 0;
  int          mismatched = 0;

  cache_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  cache_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .CELL_CNT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .hit_cnt (hit_cnt),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with the controller idle; plays CPU and memory until the response,
  // then advances one more negedge so the next call also starts at a negedge.
  task automatic txn(input logic we, input logic [7:0] a, input logic [7:0] wd,
                     input logic [7:0] md, input int dly, input bit hold, input bit junk,
                     output int lat, output int nmem, output logic [7:0] rd, output bit bus_ok);
    int mcyc = 0;
    bit prev = 1'b0;
    lat = -1;
    nmem = 0;
    rd = 'x;
    bus_ok = (bus.req_ready === 1'b1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    @(posedge clk);
    for (int cyc = 1; cyc <= 60 && lat < 0; cyc++) begin
      @(negedge clk);
      if (!hold) bus.req_valid = 1'b0;
      bus.mem_ack   = junk;
      bus.mem_rdata = ~md;
      if (bus.req_ready !== 1'b0) bus_ok = 1'b0;
      if (bus.mem_req) begin
        if (!prev) nmem++;
        if (bus.mem_addr !== a || bus.mem_we !== we || (we && bus.mem_wdata !== wd)) bus_ok = 1'b0;
        mcyc++;
        if (mcyc == dly + 1) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = md;
        end
      end
      prev = bus.mem_req;
      if (bus.rsp_valid) begin
        lat = cyc;
        rd  = bus.rsp_rdata;
      end
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) bus_ok = 1'b0;
  endtask

  initial begin
    int lat, nmem;
    logic [7:0] rd;
    bit ok;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    #3;
    check("rst_req_ready", 32'(bus.req_ready), 1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_mem_req", 32'(bus.mem_req), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    check("rst_hit_cnt", 32'(hit_cnt), 0);
    check("rst_miss_cnt", 32'(miss_cnt), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // cold read miss, ack on the 4th request cycle
    txn(1'b0, 8'h10, 8'h00, 8'hA5, 3, 1'b0, 1'b0, lat, nmem, rd, ok);
    check("cold_lat", 32'(lat), 6);
    check("cold_nmem", 32'(nmem), 1);
    check("cold_rdata", 32'(rd), 'hA5);
    check("cold_bus", 32'(ok), 1);
    check("cold_miss", 32'(miss_cnt), 1);
    check("cold_hit", 32'(hit_cnt), 0);

    // read hit with a stray mem_ack held high
    txn(1'b0, 8'h10, 8'h00, 8'h5A, 0, 1'b0, 1'b1, lat, nmem, rd, ok);
    check("hit_lat", 32'(lat), 2);
    check("hit_nmem", 32'(nmem), 0);
    check("hit_rdata", 32'(rd), 'hA5);
    check("hit_hit", 32'(hit_cnt), 1);
    check("hit_miss", 32'(miss_cnt), 1);

    // write-through then read-back hit
    txn(1'b1, 8'h20, 8'h3C, 8'hEE, 1, 1'b0, 1'b0, lat, nmem, rd, ok);
    check("wr_lat", 32'(lat), 4);
    check("wr_nmem", 32'(nmem), 1);
    check("wr_bus", 32'(ok), 1);
    check("wr_rdata_hold", 32'(rd), 'hA5);
    check("wr_not_counted", 32'({hit_cnt, miss_cnt}), 32'h0001_0001);
    txn(1'b0, 8'h20, 8'h00, 8'hEE, 0, 1'b0, 1'b0, lat, nmem, rd, ok);
    check("wrrd_nmem", 32'(nmem), 0);
    check("wrrd_rdata", 32'(rd), 'h3C);
    check("wrrd_hit", 32'(hit_cnt), 2);

    // eviction: 0x05 shares an entry with 0x01
    for (int i = 1; i <= 5; i++) begin
      txn(1'b0, 8'(i), 8'h00, 8'(8'h40 + i), 0, 1'b0, 1'b0, lat, nmem, rd, ok);
      check($sformatf("ev%0d_nmem", i), 32'(nmem), 1);
      check($sformatf("ev%0d_lat", i), 32'(lat), 3);
    end
    check("ev_miss", 32'(miss_cnt), 6);
    txn(1'b0, 8'h01, 8'h00, 8'h77, 0, 1'b0, 1'b0, lat, nmem, rd, ok);
    check("evict_refetch_nmem", 32'(nmem), 1);
    check("evict_refetch_rdata", 32'(rd), 'h77);
    check("evict_miss", 32'(miss_cnt), 7);
    txn(1'b0, 8'h02, 8'h00, 8'hEE, 0, 1'b0, 1'b0, lat, nmem, rd, ok);
    check("keep_02_rdata", 32'(rd), 'h42);
    check("keep_02_nmem", 32'(nmem), 0);

    // req_valid held high through a miss: one response, re-accepted only after RESP
    txn(1'b0, 8'h06, 8'h00, 8'h66, 2, 1'b1, 1'b0, lat, nmem, rd, ok);
    check("stall_lat", 32'(lat), 5);
    check("stall_bus", 32'(ok), 1);
    check("stall_miss", 32'(miss_cnt), 8);
    txn(1'b0, 8'h06, 8'h00, 8'hEE, 0, 1'b0, 1'b0, lat, nmem, rd, ok);
    check("stall2_lat", 32'(lat), 2);
    check("stall2_rdata", 32'(rd), 'h66);
    check("stall2_hit", 32'(hit_cnt), 4);

    // reset while MEM_RD is requesting
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'h30;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("mid_req_before", 32'(bus.mem_req), 1);
    #2 rst = 1'b0;
    #1;
    check("mid_req_dropped", 32'(bus.mem_req), 0);
    check("mid_ready", 32'(bus.req_ready), 1);
    check("mid_counters", 32'({hit_cnt, miss_cnt}), 0);
    check("mid_rsp_rdata", 32'(bus.rsp_rdata), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || bus.mem_req !== 1'b0) ok = 1'b0;
    end
    check("mid_quiet", 32'(ok), 1);
    txn(1'b0, 8'h30, 8'h00, 8'h31, 0, 1'b0, 1'b0, lat, nmem, rd, ok);
    check("post_rst_nmem", 32'(nmem), 1);
    check("post_rst_rdata", 32'(rd), 'h31);
    txn(1'b0, 8'h03, 8'h00, 8'h13, 0, 1'b0, 1'b0, lat, nmem, rd, ok);
    check("post_rst_cleared", 32'(nmem), 1);
    check("post_rst_miss", 32'(miss_cnt), 2);

    // saturation, starting the counters just below the top
    dut.miss_q = 16'hFFFE;
    txn(1'b0, 8'h50, 8'h00, 8'h55, 0, 1'b0, 1'b0, lat, nmem, rd, ok);
    check("sat_miss_top", 32'(miss_cnt), 'hFFFF);
    txn(1'b0, 8'h61, 8'h00, 8'h61, 0, 1'b0, 1'b0, lat, nmem, rd, ok);
    check("sat_miss_hold", 32'(miss_cnt), 'hFFFF);
    dut.hit_q = 16'hFFFE;
    txn(1'b0, 8'h61, 8'h00, 8'hEE, 0, 1'b0, 1'b0, lat, nmem, rd, ok);
    check("sat_hit_top", 32'(hit_cnt), 'hFFFF);
    txn(1'b0, 8'h50, 8'h00, 8'hEE, 0, 1'b0, 1'b0, lat, nmem, rd, ok);
    check("sat_hit_hold", 32'(hit_cnt), 'hFFFF);
    check("sat_hit_rdata", 32'(rd), 'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
